mux_row_reader: RTL and testbench
=================================

# mux_row_reader

Sequential read controller that sits directly downstream of the 16:1 column mux in the RAM read path. It drives the mux's 4-bit column select, waits a programmable settle time, samples the single-bit mux output, and assembles the sampled bits into a 16-bit word. A start/busy/valid handshake exposes the assembled word to the RAM access logic, with support for partial and wrapping column ranges and for abort.

## Interface
- SETTLE, default 1: extra cycles `sel` is held before sampling; legal range 0..7.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a scan; accepted only when `busy`=0.
- abort  input  1  cancel an in-progress scan; ignored when idle.
- first_col  input  4  first column index to read; latched on accepted `start`.
- count  input  5  number of columns to read; 1..16, value 0 means 16; latched on accepted `start`.
- mux_out  input  1  single-bit output of the column mux.
- sel  output  4  column select to the mux.
- data  output  16  assembled word; bit k holds the sample from column k.
- busy  output  1  high while a scan is in progress.
- valid  output  1  one-cycle pulse when `data` is complete.

## Operation
- Reset values: `sel`=0, `data`=0, `busy`=0, `valid`=0, state IDLE, settle counter 0, remaining count 0.
- States: IDLE and SCAN.
- IDLE: `sel` holds its last value. On `start`=1, the block takes these actions at the next edge:
  - `sel`<=`first_col`.
  - `data`<=0.
  - remaining<=`count` (0 maps to 16).
  - settle counter<=SETTLE.
  - `busy`<=1.
  - state<=SCAN.
- SCAN, settle counter > 0: decrement the counter; `sel` is held.
- SCAN, settle counter = 0 (sample edge):
  - `data[sel]`<=`mux_out`.
  - remaining decrements.
  - If remaining was 1: state<=IDLE, `busy`<=0, `valid`<=1, and `sel` is held.
  - Otherwise: `sel`<=`sel`+1 modulo 16 (15 wraps to 0), and settle counter<=SETTLE.
- `valid` clears at the edge after it is set, unconditionally.
- Bits of `data` not visited in a partial scan read 0.
- `start` while `busy`=1 is ignored, and the latched parameters are unchanged.
- `start` in the cycle where `valid`=1 is accepted, because the block is already IDLE.
- `abort`=1 in SCAN: the next edge sets state IDLE and `busy`<=0. `valid` is not asserted. `data` keeps the partial result and `sel` holds. `abort` has priority over a coincident sample edge, so that sample is not written.
- A column is never resampled within one scan. A scan with count=16 visits every column exactly once regardless of `first_col`.
- `data` is stable from the `valid` pulse until the next accepted `start`.

## Timing
- `start` is sampled at edge t0. `sel`=`first_col` is valid from t0.
- Column j (j=0..n-1) is presented from edge t0+j(SETTLE+1) and sampled at edge t0+(j+1)(SETTLE+1).
  - `mux_out` is sampled after `sel` has been stable for SETTLE+1 full cycles.
- The final sample lands at edge t0+n(SETTLE+1). At that same edge `valid` rises and `busy` falls.
- `valid` falls at edge t0+n(SETTLE+1)+1.
- Latency is n(SETTLE+1) cycles from the `start` edge to `valid`. With SETTLE=1 and n=16 this is 32 cycles.
- Back-to-back throughput: a new `start` can be accepted in the `valid` cycle. There are no dead cycles between scans.
- `rst` asserted at any time forces all reset values immediately, without waiting for a clock edge. Operation resumes in IDLE at the first edge after `rst` deasserts.
- All outputs are registered.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` mid-clock, then deassert it.
  - Required response: `sel`=0, `data`=0, `busy`=0 and `valid`=0 are observed before the next edge. With no `start`, the outputs stay constant for 20 cycles.
- Full-row read:
  - Setup: SETTLE=1; the bench models the mux as `mux_out`=pattern[`sel`] with pattern=16'hA5C3.
  - Stimulus: `start` with `first_col`=0, `count`=0.
  - Required response: `data`=16'hA5C3 at the `valid` pulse 32 cycles after the `start` edge. `sel` steps 0..15, each value held exactly 2 cycles. `valid` is high for exactly 1 cycle.
- Wrap-around partial read:
  - Setup: SETTLE=0, pattern=16'hFFFF.
  - Stimulus: `start` with `first_col`=14, `count`=4.
  - Required response: `sel` sequence is 14, 15, 0, 1. `data`=16'hC003 at `valid`, 4 cycles after `start`. The final `sel` holds at 1.
- Handshake collisions:
  - Stimulus: pulse `start` with different `first_col` while `busy`=1.
  - Required response: the scan continues unchanged.
  - Stimulus: issue `start` in the `valid` cycle.
  - Required response: the second scan is accepted, and `busy` re-rises on the next edge.
- Abort and reset mid-scan:
  - Setup: SETTLE=1, pattern=16'hFFFF, full read.
  - Stimulus: `abort` at cycle 7 after `start`.
  - Required response: `busy` falls next edge, `valid` never pulses, `data`=16'h0007 (columns 0..2 sampled).
  - Stimulus: repeat the scan and assert `rst` at cycle 9 instead.
  - Required response: all reset values are restored immediately.

Source files
------------

// File: rtl/mux_row_reader.sv
// Sequential reader for a 16:1 column mux: steps the column select, waits SETTLE
// cycles per column, samples mux_out and assembles the bits into a 16-bit word.
module mux_row_reader #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  first_col,
    input  logic [4:0]  count,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic [15:0] data,
    output logic        busy,
    output logic        valid
);

    localparam logic [2:0] SETTLE_V = 3'(SETTLE);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  sel_reg, sel_next;
    logic [15:0] data_reg, data_next;
    logic        busy_reg, busy_next;
    logic        valid_reg, valid_next;
    logic [2:0]  settle_reg, settle_next;
    logic [4:0]  remaining_reg, remaining_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= 4'd0;
            data_reg      <= 16'd0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            settle_reg    <= 3'd0;
            remaining_reg <= 5'd0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            data_reg      <= data_next;
            busy_reg      <= busy_next;
            valid_reg     <= valid_next;
            settle_reg    <= settle_next;
            remaining_reg <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        data_next      = data_reg;
        busy_next      = busy_reg;
        valid_next     = 1'b0;
        settle_next    = settle_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sel_next       = first_col;
                    data_next      = 16'd0;
                    remaining_next = (count == 5'd0) ? 5'd16 : count;
                    settle_next    = SETTLE_V;
                    busy_next      = 1'b1;
                    state_next     = SCAN;
                end
            end
            SCAN: begin
                // abort wins over a coincident sample edge, so that sample is dropped
                if (abort) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (settle_reg != 3'd0) begin
                    settle_next = settle_reg - 3'd1;
                end else begin
                    data_next[sel_reg] = mux_out;
                    remaining_next     = remaining_reg - 5'd1;
                    if (remaining_reg == 5'd1) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        valid_next = 1'b1;
                    end else begin
                        sel_next    = sel_reg + 4'd1;
                        settle_next = SETTLE_V;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel   = sel_reg;
    assign data  = data_reg;
    assign busy  = busy_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_mux_row_reader.sv
// Directed bench for mux_row_reader: two instances (SETTLE=1 and SETTLE=0) each
// driven by a modelled column mux with a programmable pattern.
module tb_mux_row_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  first_col;
    logic [4:0]  count;
    logic [15:0] pat1, pat0;
    logic        mux_out1, mux_out0;
    logic [3:0]  sel1, sel0;
    logic [15:0] data1, data0;
    logic        busy1, busy0, valid1, valid0;

    int checks;
    int errors;

    mux_row_reader #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_col(first_col), .count(count), .mux_out(mux_out1),
        .sel(sel1), .data(data1), .busy(busy1), .valid(valid1)
    );

    mux_row_reader #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_col(first_col), .count(count), .mux_out(mux_out0),
        .sel(sel0), .data(data0), .busy(busy0), .valid(valid0)
    );

    assign mux_out1 = pat1[sel1];
    assign mux_out0 = pat0[sel0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] fc, input logic [4:0] cnt);
        start     = 1'b1;
        first_col = fc;
        count     = cnt;
        tick();
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        first_col = 4'd0; count = 5'd0;
        pat1 = 16'hA5C3; pat0 = 16'hFFFF;

        // reset asserted between edges takes effect immediately
        #2 rst = 1'b1;
        #1;
        chk("rst_dut1", {sel1, data1, busy1, valid1}, 22'd0);
        chk("rst_dut0", {sel0, data0, busy0, valid0}, 22'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_hold", {sel1, data1, busy1, valid1, sel0, data0, busy0, valid0}, 44'd0);
        end

        // full row, SETTLE=1: each column held 2 cycles, valid 32 cycles after start
        pat1 = 16'hA5C3;
        do_start(4'd0, 5'd0);
        chk("full_busy", busy1, 1'b1);
        chk("full_sel0", sel1, 4'd0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("full_sel", sel1, (k < 32) ? 32'(k / 2) : 32'd15);
            chk("full_valid", valid1, (k == 32) ? 1'b1 : 1'b0);
        end
        chk("full_data", data1, 16'hA5C3);
        chk("full_busy_end", busy1, 1'b0);
        tick();
        chk("full_valid_clr", valid1, 1'b0);
        chk("full_data_hold", data1, 16'hA5C3);

        // wrapping partial read, SETTLE=0
        pat0 = 16'hFFFF;
        do_start(4'd14, 5'd4);
        chk("wrap_sel_t0", sel0, 4'd14);
        tick(); chk("wrap_sel_1", sel0, 4'd15);
        tick(); chk("wrap_sel_2", sel0, 4'd0);
        tick(); chk("wrap_sel_3", sel0, 4'd1);
        chk("wrap_valid_early", valid0, 1'b0);
        tick();
        chk("wrap_valid", valid0, 1'b1);
        chk("wrap_data", data0, 16'hC003);
        chk("wrap_sel_hold", sel0, 4'd1);
        tick();
        chk("wrap_valid_clr", valid0, 1'b0);
        repeat (4) tick();

        // start while busy is ignored; start in the valid cycle is accepted
        pat1 = 16'hFFFF;
        do_start(4'd3, 5'd2);
        chk("coll_sel_t0", sel1, 4'd3);
        do_start(4'd9, 5'd5);
        tick();
        chk("coll_sel_2", sel1, 4'd4);
        tick();
        chk("coll_valid_early", valid1, 1'b0);
        start = 1'b1; first_col = 4'd7; count = 5'd1;
        tick();
        start = 1'b0;
        chk("coll_valid", valid1, 1'b1);
        chk("coll_data", data1, 16'h0018);
        chk("coll_busy_low", busy1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy1, 1'b1);
        chk("b2b_sel", sel1, 4'd7);
        chk("b2b_data_clr", data1, 16'h0000);
        chk("b2b_valid_clr", valid1, 1'b0);
        tick(); tick();
        chk("b2b_valid", valid1, 1'b1);
        chk("b2b_data", data1, 16'h0080);
        repeat (4) tick();

        // abort at cycle 7 of a full scan: columns 0..2 captured, no valid
        pat1 = 16'hFFFF;
        do_start(4'd0, 5'd0);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy1, 1'b0);
        chk("abort_data", data1, 16'h0007);
        chk("abort_sel", sel1, 4'd3);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_valid", valid1, 1'b0);
            tick();
        end
        chk("abort_data_hold", data1, 16'h0007);

        // reset mid-scan restores reset values without a clock edge
        do_start(4'd0, 5'd0);
        repeat (8) tick();
        chk("pre_rst_busy", busy1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_dut1", {sel1, data1, busy1, valid1}, 22'd0);
        chk("midrst_dut0", {sel0, data0, busy0, valid0}, 22'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", {sel1, data1, busy1, valid1}, 22'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
